stall_flush_controller: RTL and testbench
=========================================

# stall_flush_controller

Pipeline control sequencer for the 5-stage RISC-V core. It sits beside the forwarding hazard unit and decides when the pipeline must stall or flush. Three hazards are covered:
- load-use hazards that forwarding cannot resolve;
- control hazards from branches and jumps resolved in Execute;
- multi-cycle data-memory accesses in Memory, guarded by a timeout.

Optional hazard statistics are compiled in by macro.

## Interface
Parameters:
- MAX_WAIT, 15: maximum consecutive memory-wait stall cycles before forced release; legal range 1..255.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- RS1D, RS2D  in  5 each  source registers of the instruction in Decode.
- RDE  in  5  destination register of the instruction in Execute.
- ResultSrcE0  in  1  high when the instruction in Execute is a load.
- PCSrcE  in  1  high when a taken branch or jump resolves in Execute.
- MemReqM  in  1  the instruction in Memory accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the corresponding pipeline register.
- MemErr  out  1  one-cycle pulse on a memory-wait timeout.

## Operation
- FSM states: RUN and MEM_WAIT. State and wait counter are registered; all control outputs are combinational from the current state and the inputs (Mealy).
- Memory stall condition: MemReqM=1 and MemReadyM=0.
  - Response: StallF, StallD, StallE and StallM are asserted, FlushW=1, and FlushD and FlushE are forced to 0.
- Load-use condition: ResultSrcE0=1, RDE≠0, and RDE equals RS1D or RS2D.
  - Response: StallF=1, StallD=1, FlushE=1.
  - Lasts exactly one cycle, because the bubble removes the load from Execute.
- Control flush condition: PCSrcE=1.
  - Response: FlushD=1, FlushE=1.
- Priority when conditions coincide:
  - A memory stall beats everything else.
  - A control flush beats load-use: stalls are suppressed and the flushes apply.
  - Deferred hazards are re-evaluated on the release cycle, because Execute and Decode were held.
- RUN → MEM_WAIT when the memory stall condition holds; the wait counter is set to 1.
- In MEM_WAIT, each cycle:
  - MemReadyM=1: no memory stall this cycle, go to RUN, counter cleared.
  - MemReadyM=0 and counter < MAX_WAIT: stall, counter increments.
  - MemReadyM=0 and counter = MAX_WAIT: no stall this cycle, MemErr=1, go to RUN. The Memory instruction advances.
- MemReadyM=1 in the same cycle as a new MemReqM means zero stall cycles and no state change.
- Reset: while reset_n=0 at an edge, the state becomes RUN and the counter is cleared. During any cycle with reset_n=0, all outputs are forced to 0 regardless of the inputs.
- Reset mid-wait abandons the access silently; MemErr is not pulsed.

## Timing
- Stall and flush outputs are valid in the same cycle as their causing inputs (zero latency), so the pipeline registers act on the same edge.
- Load-use adds exactly 1 stall cycle.
- A memory wait adds N stall cycles, where N is the number of cycles with MemReadyM low, capped at MAX_WAIT.
- MemErr is high for exactly one cycle: the release cycle.
- The wait counter is ceil(log2(MAX_WAIT+1)) bits wide and never wraps.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds output ports LoadStallCnt, MemStallCnt and FlushCnt, each CNT_W wide and reset to 0.
  - Each increments on every cycle its response is actually applied; a suppressed response is not counted.
  - Each counter saturates at all-ones.
- HAZARD_STATS_EN undefined: these ports and registers do not exist. Control behaviour is identical either way.

## Structure
- Shared package pipeline_ctrl_pkg:
  - ctrl_state_t enum (RUN, MEM_WAIT).
  - Register-zero constant REG_X0 = 5'd0.
- One sub-module, mem_wait_timer, holds the wait counter. It has a MAX_WAIT parameter, inputs start/clear, and output expired.

## Test plan
- Load-use: RDE=5, ResultSrcE0=1, RS1D=5 → StallF=StallD=FlushE=1 for one cycle. With RDE=0 → all outputs 0.
- Branch: PCSrcE=1 together with a load-use match → FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM low for 3 cycles then high → StallF/D/E/M and FlushW high for exactly 3 cycles, state back to RUN, MemErr=0.
- Timeout: MAX_WAIT=4, MemReadyM held 0 → stalls for 4 cycles, then MemErr=1 for one cycle with stalls low.
- Deferred hazard: memory wait while PCSrcE=1 → FlushD/E held 0 during the wait and asserted on the release cycle.
- Reset: reset_n=0 during MEM_WAIT → all outputs 0, state RUN. With HAZARD_STATS_EN defined, the counters read 0 afterwards.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush control slice.
package pipeline_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} ctrl_state_t;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles; saturates at MAX_WAIT and reports expiry.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] cnt;

  // Counts on its own while a wait is open; the controller clears it on release.
  always_ff @(posedge clk) begin
    if (!reset_n || clear)                        cnt <= '0;
    else if (start)                               cnt <= W'(1);
    else if (cnt != '0 && cnt != W'(MAX_WAIT))    cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == W'(MAX_WAIT));
endmodule

// File: rtl/stall_flush_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use, control flush, memory wait.
// Define HAZARD_STATS_EN to add saturating hazard statistics counters.
module stall_flush_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] RS1D,
  input  logic [4:0] RS2D,
  input  logic [4:0] RDE,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemErr
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] LoadStallCnt,
  output logic [CNT_W-1:0] MemStallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);
  ctrl_state_t state, state_n;
  logic        start, clear, expired;
  logic        mem_stall, mem_err, load_use;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .clear   (clear),
    .expired (expired)
  );

  assign load_use = ResultSrcE0 && (RDE != REG_X0) && ((RDE == RS1D) || (RDE == RS2D));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    clear     = 1'b0;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    case (state)
      RUN: if (MemReqM && !MemReadyM) begin
        mem_stall = 1'b1;
        start     = 1'b1;
        state_n   = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          clear   = 1'b1;
          state_n = RUN;
        end else if (!expired) begin
          mem_stall = 1'b1;
        end else begin
          // Timeout: release the Memory instruction and flag it
          mem_err = 1'b1;
          clear   = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushW = 1'b0; MemErr = 1'b0;
    if (reset_n) begin
      if (mem_stall) begin
        {StallF, StallD, StallE, StallM, FlushW} = '1;
      end else begin
        // Held hazards surface here on the release cycle
        MemErr = mem_err;
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Counters follow the applied outputs, so suppressed responses are not counted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      LoadStallCnt <= '0;
      MemStallCnt  <= '0;
      FlushCnt     <= '0;
    end else begin
      if (StallD && !StallM && LoadStallCnt != '1) LoadStallCnt <= LoadStallCnt + 1'b1;
      if (StallM && MemStallCnt != '1)             MemStallCnt  <= MemStallCnt + 1'b1;
      if (FlushD && FlushCnt != '1)                FlushCnt     <= FlushCnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_stall_flush_controller.sv
// Directed self-checking bench for stall_flush_controller (MAX_WAIT=4).
module tb_stall_flush_controller;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] RS1D, RS2D, RDE;
  logic       ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_STATS_EN
  logic [15:0] LoadStallCnt, MemStallCnt, FlushCnt;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stall_flush_controller #(.MAX_WAIT(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .RS1D(RS1D), .RS2D(RS2D), .RDE(RDE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr)
`ifdef HAZARD_STATS_EN
    , .LoadStallCnt(LoadStallCnt), .MemStallCnt(MemStallCnt), .FlushCnt(FlushCnt)
`endif
  );

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemErr}
  wire [7:0] outv = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr};

  task automatic idle();
    RS1D = 5'd0; RS2D = 5'd0; RDE = 5'd0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    ResultSrcE0 = 1'b1; RDE = 5'd3; RS1D = 5'd3;
    @(negedge clk);
    checks++;
    if (outv !== 8'b0000_0000) begin errors++; $display("FAIL reset_outputs got %b want %b", outv, 8'b0); end
    @(posedge clk); #1;
    reset_n = 1'b1; idle();
    @(negedge clk);
    checks++;
    if (outv !== 8'b0000_0000) begin errors++; $display("FAIL reset_idle got %b want %b", outv, 8'b0); end
  endtask

  task automatic test_load_use();
    logic [4:0] rde_v [4] = '{5'd5, 5'd7, 5'd0, 5'd9};
    logic [4:0] rs1_v [4] = '{5'd5, 5'd1, 5'd0, 5'd8};
    logic [4:0] rs2_v [4] = '{5'd2, 5'd7, 5'd0, 5'd8};
    logic [7:0] exp_v [4] = '{8'b1100_0100, 8'b1100_0100, 8'b0000_0000, 8'b0000_0000};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      idle(); ResultSrcE0 = 1'b1; RDE = rde_v[i]; RS1D = rs1_v[i]; RS2D = rs2_v[i];
      @(negedge clk);
      checks++;
      if (outv !== exp_v[i]) begin errors++; $display("FAIL load_use[%0d] got %b want %b", i, outv, exp_v[i]); end
    end
    // Bubble removed the load: next cycle carries no hazard
    @(posedge clk); #1; idle(); RS1D = 5'd5;
    @(negedge clk);
    checks++;
    if (outv !== 8'b0000_0000) begin errors++; $display("FAIL load_use_after got %b want %b", outv, 8'b0); end
  endtask

  task automatic test_branch();
    @(posedge clk); #1;
    idle(); PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RDE = 5'd5; RS1D = 5'd5;
    @(negedge clk);
    checks++;
    if (outv !== 8'b0000_1100) begin errors++; $display("FAIL branch_over_load got %b want %b", outv, 8'b0000_1100); end
  endtask

  task automatic test_zero_stall();
    @(posedge clk); #1;
    idle(); MemReqM = 1'b1; MemReadyM = 1'b1;
    @(negedge clk);
    checks++;
    if (outv !== 8'b0000_0000) begin errors++; $display("FAIL zero_stall got %b want %b", outv, 8'b0); end
  endtask

  task automatic test_mem_wait();
    logic [7:0] exp_v [5] = '{8'b1111_0010, 8'b1111_0010, 8'b1111_0010, 8'b0000_0000, 8'b0000_0000};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      idle(); MemReqM = (i < 4); MemReadyM = (i == 3);
      @(negedge clk);
      checks++;
      if (outv !== exp_v[i]) begin errors++; $display("FAIL mem_wait[%0d] got %b want %b", i, outv, exp_v[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_v [7] = '{8'b1111_0010, 8'b1111_0010, 8'b1111_0010, 8'b1111_0010,
                             8'b0000_0001, 8'b0000_0000, 8'b1111_0010};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      idle(); MemReqM = (i != 5); MemReadyM = 1'b0;
      @(negedge clk);
      checks++;
      if (outv !== exp_v[i]) begin errors++; $display("FAIL timeout[%0d] got %b want %b", i, outv, exp_v[i]); end
    end
    @(posedge clk); #1; idle(); MemReqM = 1'b1; MemReadyM = 1'b1;
    @(negedge clk);
    checks++;
    if (outv !== 8'b0000_0000) begin errors++; $display("FAIL timeout_drain got %b want %b", outv, 8'b0); end
  endtask

  task automatic test_deferred();
    logic [7:0] exp_v [4] = '{8'b1111_0010, 8'b1111_0010, 8'b0000_1100, 8'b0000_0000};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      idle(); PCSrcE = (i < 3); MemReqM = (i < 3); MemReadyM = (i == 2);
      @(negedge clk);
      checks++;
      if (outv !== exp_v[i]) begin errors++; $display("FAIL deferred[%0d] got %b want %b", i, outv, exp_v[i]); end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; idle(); MemReqM = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (outv !== 8'b1111_0010) begin errors++; $display("FAIL mid_reset_wait got %b want %b", outv, 8'b1111_0010); end
    @(posedge clk); #1; reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (outv !== 8'b0000_0000) begin errors++; $display("FAIL mid_reset_out got %b want %b", outv, 8'b0); end
    @(posedge clk); #1; reset_n = 1'b1; idle();
    @(negedge clk);
    checks++;
    if (outv !== 8'b0000_0000) begin errors++; $display("FAIL mid_reset_noerr got %b want %b", outv, 8'b0); end
`ifdef HAZARD_STATS_EN
    checks++;
    if ({LoadStallCnt, MemStallCnt, FlushCnt} !== 48'd0) begin
      errors++; $display("FAIL stats_cleared got %h want 0", {LoadStallCnt, MemStallCnt, FlushCnt});
    end
`endif
    // Counter must restart from 1: full four-cycle wait then timeout
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; idle(); MemReqM = 1'b1;
      @(negedge clk);
      checks++;
      if (outv !== ((i < 4) ? 8'b1111_0010 : 8'b0000_0001)) begin
        errors++; $display("FAIL post_reset_wait[%0d] got %b", i, outv);
      end
    end
    @(posedge clk); #1; idle();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_zero_stall();
    test_mem_wait();
    test_timeout();
    test_deferred();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
